// File: rtl/mem_stage.sv
// MEM pipeline stage: runs the data-memory handshake, stalls upstream while waiting
// for ack, aborts an access after MAX_WAIT cycles in WAIT, and holds the MEM/WB register.
module mem_stage #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_MemToReg_in,
   input  logic        wb_RegWrite_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [31:0] ALURes_in,
   input  logic [31:0] D2_in,
   input  logic [4:0]  RegDest_in,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   input  logic        err_clr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        stall,
   output logic        wb_MemToReg_out,
   output logic        wb_RegWrite_out,
   output logic [31:0] ReadData_out,
   output logic [31:0] ALURes_out,
   output logic [4:0]  RegDest_out,
   output logic        mem_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        mtr_q, rw_q;
   logic [31:0] rdata_q, alu_q;
   logic [4:0]  rd_q;

   logic        acc, bad, timeout, complete, err_set, bubble;

   assign acc     = MemRead_in | MemWrite_in;
   assign bad     = (acc & (ALURes_in[1:0] != 2'b00)) | (MemRead_in & MemWrite_in);
   assign timeout = (state_q == S_WAIT) & (cnt_q == LAST_CNT);

   // Gated by rst so an in-flight request disappears the moment reset asserts,
   // even though upstream still presents the (now discarded) memory instruction.
   assign dmem_req   = rst & (((state_q == S_IDLE) & acc & ~bad) | (state_q == S_WAIT));
   assign dmem_we    = MemWrite_in & dmem_req;
   assign dmem_addr  = ALURes_in;
   assign dmem_wdata = D2_in;
   assign stall      = dmem_req & ~dmem_ack & ~timeout;
   assign complete   = dmem_req & dmem_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bad) begin
               err_set = 1'b1;
            end else if (dmem_req && !dmem_ack) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               state_d = S_IDLE;
            end else if (timeout) begin
               state_d = S_IDLE;
               err_set = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
   end

   // Set wins over clear when both land in the same cycle.
   assign err_d  = err_set | (err_q & ~err_clr);
   assign bubble = stall | err_set;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtr_q   <= 1'b0;
         rw_q    <= 1'b0;
         rdata_q <= '0;
         alu_q   <= '0;
         rd_q    <= '0;
      end else begin
         mtr_q   <= wb_MemToReg_in & ~bubble;
         rw_q    <= wb_RegWrite_in & ~bubble;
         rdata_q <= (complete & MemRead_in) ? dmem_rdata : '0;
         alu_q   <= ALURes_in;
         rd_q    <= RegDest_in;
      end
   end

   assign wb_MemToReg_out = mtr_q;
   assign wb_RegWrite_out = rw_q;
   assign ReadData_out    = rdata_q;
   assign ALURes_out      = alu_q;
   assign RegDest_out     = rd_q;
   assign mem_err         = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a per-instruction model predicts every cycle of
// each access from its ack schedule, plus hand-computed literal checks.
module tb_mem_stage;

   localparam int unsigned MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_MemToReg_in, wb_RegWrite_in, MemRead_in, MemWrite_in;
   logic [31:0] ALURes_in, D2_in;
   logic [4:0]  RegDest_in;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        err_clr;
   logic        dmem_req, dmem_we, stall;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        wb_MemToReg_out, wb_RegWrite_out;
   logic [31:0] ReadData_out, ALURes_out;
   logic [4:0]  RegDest_out;
   logic        mem_err;

   mem_stage #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .wb_MemToReg_in(wb_MemToReg_in), .wb_RegWrite_in(wb_RegWrite_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .ALURes_in(ALURes_in), .D2_in(D2_in), .RegDest_in(RegDest_in),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .err_clr(err_clr),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .stall(stall),
      .wb_MemToReg_out(wb_MemToReg_out), .wb_RegWrite_out(wb_RegWrite_out),
      .ReadData_out(ReadData_out), .ALURes_out(ALURes_out),
      .RegDest_out(RegDest_out), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic        chk_en = 1'b0;
   logic        exp_req, exp_stall, exp_we, exp_mtr, exp_rw, m_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdata, exp_alu;
   logic [4:0]  exp_rd;
   int          obs_stall, obs_we, obs_req, obs_nb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      exp_mtr   = 1'b0;
      exp_rw    = 1'b0;
      exp_rdata = '0;
      exp_alu   = '0;
      exp_rd    = '0;
      m_err     = 1'b0;
   endtask

   // Compare process: every cycle the model is active, all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("dmem_req",   32'(dmem_req),        32'(exp_req));
         check("stall",      32'(stall),           32'(exp_stall));
         check("dmem_we",    32'(dmem_we),         32'(exp_we));
         check("dmem_addr",  dmem_addr,            exp_addr);
         check("dmem_wdata", dmem_wdata,           exp_wdata);
         check("wb_mtr_out", 32'(wb_MemToReg_out), 32'(exp_mtr));
         check("wb_rw_out",  32'(wb_RegWrite_out), 32'(exp_rw));
         check("rdata_out",  ReadData_out,         exp_rdata);
         check("alures_out", ALURes_out,           exp_alu);
         check("regdest",    32'(RegDest_out),     32'(exp_rd));
         check("mem_err",    32'(mem_err),         32'(m_err));
      end
   end

   // One instruction, inputs held for its whole life. ack_at = cycle index of the
   // single ack pulse (-1 = never). The access ends at the ack or at cycle MW (abort).
   task automatic run(input logic rd, input logic wr, input logic mtr, input logic rw,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rdst,
                      input int ack_at, input logic [31:0] rdata, input logic clr);
      logic acc, bad, go, ok, fin, bub;
      int   last;
      acc  = rd | wr;
      bad  = (acc && (addr[1:0] != 2'b00)) || (rd && wr);
      go   = acc && !bad;
      ok   = go && (ack_at >= 0) && (ack_at <= int'(MW));
      last = !go ? 0 : (ok ? ack_at : int'(MW));
      obs_stall = 0;
      obs_we    = 0;
      obs_req   = 0;
      obs_nb    = 0;
      for (int k = 0; k <= last; k++) begin
         MemRead_in     = rd;
         MemWrite_in    = wr;
         wb_MemToReg_in = mtr;
         wb_RegWrite_in = rw;
         ALURes_in      = addr;
         D2_in          = wdata;
         RegDest_in     = rdst;
         dmem_ack       = (k == ack_at);
         dmem_rdata     = rdata;
         err_clr        = clr;
         exp_req   = go;
         exp_stall = go && (k < last);
         exp_we    = go && wr;
         exp_addr  = addr;
         exp_wdata = wdata;
         chk_en    = 1'b1;
         #1;
         if (stall)    obs_stall++;
         if (dmem_we)  obs_we++;
         if (dmem_req) obs_req++;
         @(posedge clk);
         #1;
         fin       = (k == last);
         bub       = !fin || bad || (go && !ok);
         exp_mtr   = mtr && !bub;
         exp_rw    = rw && !bub;
         exp_rdata = (fin && ok && rd) ? rdata : '0;
         exp_alu   = addr;
         exp_rd    = rdst;
         if (fin && (bad || (go && !ok))) m_err = 1'b1;
         else if (clr)                    m_err = 1'b0;
         if (wb_RegWrite_out) obs_nb++;
      end
   endtask

   initial begin
      rst = 1'b0;
      {wb_MemToReg_in, wb_RegWrite_in, MemRead_in, MemWrite_in} = '0;
      ALURes_in  = '0;
      D2_in      = '0;
      RegDest_in = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      err_clr    = 1'b0;
      clear_model();
      #12;
      check("rst_rw_out",  32'(wb_RegWrite_out), 32'd0);
      check("rst_rdata",   ReadData_out,         32'd0);
      check("rst_alures",  ALURes_out,           32'd0);
      check("rst_mem_err", 32'(mem_err),         32'd0);
      check("rst_req",     32'(dmem_req),        32'd0);
      @(negedge clk);
      rst = 1'b1;
      #2;

      // Read, immediate ack
      run(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3, 0, 32'hCAFE_F00D, 1'b0);
      check("r040_rdata", ReadData_out,    32'hCAFE_F00D);
      check("r040_stall", 32'(obs_stall),  32'd0);

      // Write, ack three cycles late
      run(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1234_5678, 5'd4, 3, 32'h0, 1'b0);
      check("r041_stall",  32'(obs_stall), 32'd3);
      check("r041_we",     32'(obs_we),    32'd4);
      check("r041_nonbub", 32'(obs_nb),    32'd1);

      // Read that never gets an ack: aborts after MW cycles in WAIT
      run(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd5, -1, 32'h1111_1111, 1'b0);
      check("r042_stall", 32'(obs_stall),       32'd4);
      check("r042_err",   32'(mem_err),         32'd1);
      check("r042_rw",    32'(wb_RegWrite_out), 32'd0);

      // ALU op with err_clr
      run(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd6, -1, 32'h0, 1'b1);
      check("clr_err", 32'(mem_err),         32'd0);
      check("alu_rw",  32'(wb_RegWrite_out), 32'd1);

      // Misaligned read
      run(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd7, -1, 32'h0, 1'b0);
      check("r043_req", 32'(obs_req),         32'd0);
      check("r043_err", 32'(mem_err),         32'd1);
      check("r043_rw",  32'(wb_RegWrite_out), 32'd0);
      run(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, -1, 32'h0, 1'b1);
      check("r043_clr", 32'(mem_err), 32'd0);

      // Read+write together with err_clr held, and a stray ack: set wins
      run(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h0, 5'd8, 0, 32'h0, 1'b1);
      check("r045_req", 32'(obs_req), 32'd0);
      check("r045_err", 32'(mem_err), 32'd1);
      run(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, -1, 32'h0, 1'b1);

      // Non-memory op with an ack that must be ignored
      run(1'b0, 1'b0, 1'b0, 1'b1, 32'hABCD, 32'h0, 5'd9, 0, 32'hFFFF_FFFF, 1'b0);
      check("nomem_rdata", ReadData_out, 32'h0);

      // Ack exactly on the last allowed WAIT cycle still completes
      run(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd10, 4, 32'h0BAD_F00D, 1'b0);
      check("edge_stall", 32'(obs_stall), 32'd4);
      check("edge_rdata", ReadData_out,   32'h0BAD_F00D);
      check("edge_err",   32'(mem_err),   32'd0);

      // Misaligned write
      run(1'b0, 1'b1, 1'b0, 1'b0, 32'h201, 32'hAAAA_5555, 5'd11, -1, 32'h0, 1'b0);
      check("mis_we",  32'(obs_we),  32'd0);
      check("mis_err", 32'(mem_err), 32'd1);

      // Reset pulsed while in WAIT
      chk_en         = 1'b0;
      MemRead_in     = 1'b1;
      MemWrite_in    = 1'b0;
      wb_MemToReg_in = 1'b1;
      wb_RegWrite_in = 1'b1;
      ALURes_in      = 32'h300;
      RegDest_in     = 5'd12;
      dmem_ack       = 1'b0;
      err_clr        = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("r044_pre_req",   32'(dmem_req), 32'd1);
      check("r044_pre_stall", 32'(stall),    32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("r044_req",    32'(dmem_req),        32'd0);
      check("r044_stall",  32'(stall),           32'd0);
      check("r044_we",     32'(dmem_we),         32'd0);
      check("r044_rw",     32'(wb_RegWrite_out), 32'd0);
      check("r044_mtr",    32'(wb_MemToReg_out), 32'd0);
      check("r044_alures", ALURes_out,           32'd0);
      check("r044_rd",     32'(RegDest_out),     32'd0);
      check("r044_err",    32'(mem_err),         32'd0);
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      #2;
      run(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd13, 1, 32'h5A5A_1234, 1'b0);
      check("r044_after_rdata", ReadData_out,          32'h5A5A_1234);
      check("r044_after_rw",    32'(wb_RegWrite_out),  32'd1);
      check("r044_after_stall", 32'(obs_stall),        32'd1);

      chk_en = 1'b0;
      #10;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
